// File: rtl/wave_pkg.sv
// Shared types and default sizes for the triggered waveform reader.
package wave_pkg;

  localparam int SAMPLING_NUM_DEF = 38400;
  localparam int WINDOW_LEN_DEF   = 640;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_STREAM,
    S_DONE
  } state_t;

endpackage

// File: rtl/trig_detect.sv
// Threshold-crossing detector: latches gate/slope at start, tracks the
// previous sample and flags the first qualifying crossing.
module trig_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic [7:0] i_gate,
  input  logic       i_slope,
  input  logic       i_sv,
  input  logic [7:0] i_data,
  output logic       o_hit,
  output logic       o_found
);

  logic [7:0] r_gate;
  logic       r_slope;
  logic [7:0] r_prev;
  logic       r_pv;
  logic       r_found;
  logic       w_rise;
  logic       w_fall;

  assign w_rise  = (r_prev < r_gate) && (i_data >= r_gate);
  assign w_fall  = (r_prev > r_gate) && (i_data <= r_gate);
  assign o_hit   = i_sv && r_pv && (r_slope ? w_fall : w_rise);
  assign o_found = r_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate  <= '0;
      r_slope <= 1'b0;
      r_prev  <= '0;
      r_pv    <= 1'b0;
      r_found <= 1'b0;
    end else if (i_clr) begin
      r_gate  <= i_gate;
      r_slope <= i_slope;
      r_pv    <= 1'b0;
      r_found <= 1'b0;
    end else if (i_sv) begin
      r_prev <= i_data;
      r_pv   <= 1'b1;
      if (o_hit) r_found <= 1'b1;
    end
  end

endmodule

// File: rtl/wave_trigger_reader.sv
// Triggered capture from sample RAM into a valid/ready pixel stream.
// Define WAVE_TRIGGER_SLOPE_EN to add the Trig_Slope (falling) option.
module wave_trigger_reader
  import wave_pkg::*;
#(
  parameter int SAMPLING_NUM = SAMPLING_NUM_DEF,
  parameter int WINDOW_LEN   = WINDOW_LEN_DEF,
  parameter int ADDR_W       = 18
) (
  input  logic              clk_system,
  input  logic              Rst,
  input  logic              Start,
  input  logic [7:0]        Trigger_Gate,
`ifdef WAVE_TRIGGER_SLOPE_EN
  input  logic              Trig_Slope,
`endif
  input  logic [7:0]        Ram_Data,
  output logic [ADDR_W-1:0] Read_Addr,
  output logic [7:0]        Pix_Data,
  output logic              Pix_Valid,
  input  logic              Pix_Ready,
  output logic              Busy,
  output logic              Trig_Found,
  output logic              Done
);

  localparam int CW = $clog2(WINDOW_LEN + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SAMPLING_NUM - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_sa;
  logic              r_sv;
  logic              r_end;
  logic [CW-1:0]     r_icnt;
  logic [CW-1:0]     r_xcnt;
  logic              r_inf;
  logic              r_pf_v;
  logic [7:0]        r_pf;
  logic [7:0]        r_pix;
  logic              r_pix_v;
  logic              w_start;
  logic              w_sv;
  logic              w_hit;
  logic              w_slope;
  logic              w_xfer;
  logic              w_last_x;
  logic              w_issue;
  logic [1:0]        w_occ_n;

`ifdef WAVE_TRIGGER_SLOPE_EN
  assign w_slope = Trig_Slope;
`else
  assign w_slope = 1'b0;
`endif

  assign w_start  = (r_state == S_IDLE) && Start;
  assign w_sv     = r_sv && (r_state == S_SEARCH);
  assign w_xfer   = r_pix_v && Pix_Ready;
  assign w_last_x = w_xfer && (r_xcnt == CW'(WINDOW_LEN - 1));

  // Output slot + prefetch slot; never let reads outrun free space.
  assign w_occ_n = 2'(r_pix_v) + 2'(r_pf_v) + 2'(r_inf) - 2'(w_xfer);
  assign w_issue = (r_state == S_STREAM) && (r_icnt != CW'(WINDOW_LEN))
                && (w_occ_n <= 2'd1);

  assign Read_Addr = r_addr;
  assign Pix_Data  = r_pix;
  assign Pix_Valid = r_pix_v;
  assign Busy      = (r_state == S_SEARCH) || (r_state == S_STREAM);
  assign Done      = (r_state == S_DONE);

  trig_detect u_trig (
    .clk     (clk_system),
    .rst_n   (Rst),
    .i_clr   (w_start),
    .i_gate  (Trigger_Gate),
    .i_slope (w_slope),
    .i_sv    (w_sv),
    .i_data  (Ram_Data),
    .o_hit   (w_hit),
    .o_found (Trig_Found)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (Start) w_next = S_SEARCH;
      S_SEARCH: if (w_sv && (w_hit || r_sa == LAST)) w_next = S_STREAM;
      S_STREAM: if (w_last_x) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_system or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk_system or negedge Rst) begin
    if (!Rst) begin
      r_addr  <= '0;
      r_sa    <= '0;
      r_sv    <= 1'b0;
      r_end   <= 1'b0;
      r_icnt  <= '0;
      r_xcnt  <= '0;
      r_inf   <= 1'b0;
      r_pf_v  <= 1'b0;
      r_pf    <= '0;
      r_pix   <= '0;
      r_pix_v <= 1'b0;
    end else begin
      r_sv  <= 1'b0;
      r_inf <= w_issue;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_addr <= '0;
            r_end  <= 1'b0;
            r_icnt <= '0;
            r_xcnt <= '0;
          end
        end
        S_SEARCH: begin
          r_sv <= !r_end;
          r_sa <= r_addr;
          if (!r_end) begin
            if (r_addr == LAST) r_end <= 1'b1;
            else                r_addr <= r_addr + ADDR_W'(1);
          end
          // Stream origin: trigger address, or 0 when none found.
          if (w_sv && w_hit)              r_addr <= r_sa;
          else if (w_sv && r_sa == LAST)  r_addr <= '0;
        end
        S_STREAM: begin
          if (w_issue) begin
            r_addr <= (r_addr == LAST) ? '0 : r_addr + ADDR_W'(1);
            r_icnt <= r_icnt + CW'(1);
          end
          if (w_xfer) r_xcnt <= r_xcnt + CW'(1);
          if (w_xfer || !r_pix_v) begin
            if (r_pf_v) begin
              r_pix   <= r_pf;
              r_pix_v <= 1'b1;
              r_pf_v  <= r_inf;
              if (r_inf) r_pf <= Ram_Data;
            end else if (r_inf) begin
              r_pix   <= Ram_Data;
              r_pix_v <= 1'b1;
            end else begin
              r_pix_v <= 1'b0;
            end
          end else if (r_inf) begin
            r_pf   <= Ram_Data;
            r_pf_v <= 1'b1;
          end
        end
        S_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_trigger_reader.sv
// Scoreboard bench for wave_trigger_reader: directed RAM images,
// expected pixel stream queued at start, checked by a negedge monitor.
module tb_wave_trigger_reader;

  localparam int N = 38400;
  localparam int W = 640;
  localparam int TMO = 45000;

  logic        clk;
  logic        Rst;
  logic        Start;
  logic [7:0]  Trigger_Gate;
  logic        Trig_Slope;
  logic [7:0]  Ram_Data;
  logic [17:0] Read_Addr;
  logic [7:0]  Pix_Data;
  logic        Pix_Valid;
  logic        Pix_Ready;
  logic        Busy;
  logic        Trig_Found;
  logic        Done;

  logic [7:0] mem [0:N-1];
  logic [7:0] sb [$];
  int errors = 0;
  int checks = 0;
  int xfers = 0;
  int done_cnt = 0;
  bit rdy_rand = 0;
  bit was_stall = 0;
  logic [7:0] held;

  wave_trigger_reader dut (
    .clk_system   (clk),
    .Rst          (Rst),
    .Start        (Start),
    .Trigger_Gate (Trigger_Gate),
`ifdef WAVE_TRIGGER_SLOPE_EN
    .Trig_Slope   (Trig_Slope),
`endif
    .Ram_Data     (Ram_Data),
    .Read_Addr    (Read_Addr),
    .Pix_Data     (Pix_Data),
    .Pix_Valid    (Pix_Valid),
    .Pix_Ready    (Pix_Ready),
    .Busy         (Busy),
    .Trig_Found   (Trig_Found),
    .Done         (Done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    Ram_Data <= (Read_Addr < 18'(N)) ? mem[Read_Addr] : 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: drives Pix_Ready, checks stall stability and pops scoreboard.
  initial begin
    Pix_Ready = 1;
    forever begin
      @(negedge clk);
      if (!Rst) was_stall = 0;
      if (was_stall) begin
        chk("stall_valid", int'(Pix_Valid), 1);
        chk("stall_data", int'(Pix_Data), int'(held));
      end
      Pix_Ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (Pix_Valid && Pix_Ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pix", int'(Pix_Data), -1);
        end else begin
          chk("pix_data", int'(Pix_Data), int'(sb.pop_front()));
        end
        xfers++;
      end
      was_stall = Pix_Valid && !Pix_Ready;
      held = Pix_Data;
      if (Done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: mem[i] = 8'(i % 256);
        1: mem[i] = 8'd50;
        2: mem[i] = 8'd0;
        default: mem[i] = 8'(255 - (i % 256));
      endcase
    end
    if (mode == 2) mem[N-1] = 8'd200;
  endtask

  task automatic push_window(input int t);
    for (int k = 0; k < W; k++) sb.push_back(mem[(t + k) % N]);
  endtask

  task automatic capture(input string nm, input logic [7:0] g,
                         input logic sl, input int t, input int f,
                         input int poke);
    int x0;
    int d0;
    bit ok;
    push_window(t);
    x0 = xfers;
    d0 = done_cnt;
    Trigger_Gate = g;
    Trig_Slope = sl;
    Start = 1;
    tick();
    Start = 0;
    Trigger_Gate = ~g;
    chk({nm, "_busy"}, int'(Busy), 1);
    chk({nm, "_addr0"}, int'(Read_Addr), 0);
    ok = 0;
    for (int c = 0; c < TMO; c++) begin
      tick();
      Start = (poke > 0) && (xfers - x0 == poke);
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    Start = 0;
    chk({nm, "_done_seen"}, int'(ok), 1);
    chk({nm, "_found"}, int'(Trig_Found), f);
    tick();
    tick();
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_xfers"}, xfers - x0, W);
    chk({nm, "_sb_left"}, sb.size(), 0);
    chk({nm, "_idle_busy"}, int'(Busy), 0);
    sb.delete();
  endtask

  initial begin
    int x0;
    int d0;
    Rst = 0;
    Start = 0;
    Trigger_Gate = 0;
    Trig_Slope = 0;
    fill(0);
    tick();
    tick();
    chk("rst_addr", int'(Read_Addr), 0);
    chk("rst_pix", int'(Pix_Data), 0);
    chk("rst_valid", int'(Pix_Valid), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_found", int'(Trig_Found), 0);
    chk("rst_done", int'(Done), 0);
    Rst = 1;
    tick();

    capture("ramp100", 8'd100, 1'b0, 100, 1, 0);
    capture("ramp255", 8'd255, 1'b0, 255, 1, 0);

    // Gate 0 never triggers: search still scanning, then abort by reset.
    d0 = done_cnt;
    Trigger_Gate = 0;
    Start = 1;
    tick();
    Start = 0;
    repeat (300) tick();
    chk("gate0_addr", int'(Read_Addr), 300);
    chk("gate0_found", int'(Trig_Found), 0);
    chk("gate0_busy", int'(Busy), 1);
    Rst = 0;
    #1;
    chk("gate0_rst_busy", int'(Busy), 0);
    tick();
    Rst = 1;
    tick();
    chk("gate0_no_done", done_cnt - d0, 0);

    fill(1);
    capture("const50", 8'd100, 1'b0, 0, 0, 0);
    fill(2);
    capture("cross_end", 8'd128, 1'b0, N - 1, 1, 0);

    fill(0);
    rdy_rand = 1;
    capture("ramp_rand", 8'd100, 1'b0, 100, 1, 0);
    rdy_rand = 0;
    tick();

    // Reset at the 300th transfer.
    push_window(100);
    x0 = xfers;
    d0 = done_cnt;
    Trigger_Gate = 100;
    Start = 1;
    tick();
    Start = 0;
    for (int c = 0; c < TMO && xfers - x0 < 300; c++) tick();
    chk("mid_reached300", xfers - x0, 300);
    @(posedge clk);
    #1;
    Rst = 0;
    #1;
    chk("mid_addr", int'(Read_Addr), 0);
    chk("mid_pix", int'(Pix_Data), 0);
    chk("mid_valid", int'(Pix_Valid), 0);
    chk("mid_busy", int'(Busy), 0);
    chk("mid_found", int'(Trig_Found), 0);
    chk("mid_done", int'(Done), 0);
    tick();
    tick();
    Rst = 1;
    tick();
    chk("mid_no_done", done_cnt - d0, 0);
    sb.delete();
    capture("after_rst", 8'd100, 1'b0, 100, 1, 0);

    capture("poke", 8'd100, 1'b0, 100, 1, 50);

`ifdef WAVE_TRIGGER_SLOPE_EN
    fill(3);
    capture("fall100", 8'd100, 1'b1, 155, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_trigger_reader.md
WAVE_TRIGGER_READER -- requirements
Module: wave_trigger_reader

Interface
REQ-001 SHALL have parameter SAMPLING_NUM, default 38400, the sample RAM depth in samples.
REQ-002 SHALL have parameter WINDOW_LEN, default 640, the number of samples streamed per capture.
REQ-003 SHALL have parameter ADDR_W, default 18, the read address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with these ports:
  clk_system  in  1  sole clock
  Rst  in  1  asynchronous active-low reset
  Start  in  1  one-cycle capture request
  Trigger_Gate  in  8  trigger threshold
  Ram_Data  in  8  sample RAM read data, valid 1 cycle after Read_Addr
  Read_Addr  out  ADDR_W  sample RAM read address
  Pix_Data  out  8  streamed sample
  Pix_Valid  out  1  Pix_Data valid
  Pix_Ready  in  1  consumer accepts Pix_Data
  Busy  out  1  high in SEARCH or STREAM
  Trig_Found  out  1  latched: trigger located in last search
  Done  out  1  one-cycle pulse at capture end

Function
REQ-005 SHALL implement the FSM states IDLE, SEARCH, STREAM and DONE.
REQ-006 SHALL, in IDLE, move to SEARCH on Start=1 and issue Read_Addr=0 on the next cycle.
REQ-007 SHALL ignore Start in every state other than IDLE.
REQ-008 SHALL, in SEARCH, issue addresses 0..SAMPLING_NUM-1 one per cycle, ascending, and compare each returned sample against the previous one.
REQ-009 SHALL define a trigger at address a (a>=1) as s[a-1] < Trigger_Gate AND s[a] >= Trigger_Gate, using unsigned 8-bit compares.
REQ-010 SHALL, on the first trigger found, latch the trigger address T, set Trig_Found=1, stop the scan and enter STREAM.
REQ-011 SHALL, if no trigger is found by address SAMPLING_NUM-1, set T=0 and Trig_Found=0, then enter STREAM (free-run display).
REQ-012 SHALL, in STREAM, deliver exactly WINDOW_LEN samples from addresses T, T+1, ..., wrapping from SAMPLING_NUM-1 to 0.
REQ-013 SHALL hold Pix_Data and Pix_Valid stable while Pix_Valid=1 and Pix_Ready=0; a transfer occurs on a cycle where both are 1.
REQ-014 SHALL sustain one transfer per cycle while Pix_Ready is held at 1, using one prefetch register to absorb the 1-cycle RAM latency.
REQ-015 SHALL not drop or duplicate any sample when Pix_Ready toggles on any cycle pattern.
REQ-016 SHALL, after the WINDOW_LEN-th transfer, enter DONE and assert Done for exactly one cycle, then return to IDLE.
REQ-017 SHALL hold Trig_Found until the next Start is accepted.
REQ-018 SHALL treat Trigger_Gate=0 as never triggering, resulting in free-run display.
REQ-019 SHALL sample Trigger_Gate once when Start is accepted; later changes have no effect on the capture in progress.

Reset
REQ-020 SHALL, on Rst=0 and in any state, asynchronously enter IDLE with Read_Addr=0, Pix_Data=0, Pix_Valid=0, Busy=0, Trig_Found=0, Done=0, and the prefetch register cleared.
REQ-021 SHALL, when Rst is asserted mid-capture, abort the capture without a Done pulse; the first Start after release starts a fresh search.

Configuration
REQ-022 SHALL, when macro WAVE_TRIGGER_SLOPE_EN is defined, add input Trig_Slope (1 bit, sampled at Start): 0 selects a rising trigger per REQ-009, 1 selects a falling trigger, s[a-1] > Trigger_Gate AND s[a] <= Trigger_Gate.
REQ-023 SHALL, when WAVE_TRIGGER_SLOPE_EN is undefined, have no Trig_Slope port and detect rising crossings only; with this option Trigger_Gate=255 never triggers falling.

Structure
REQ-024 SHALL take the FSM state enum and the default SAMPLING_NUM and WINDOW_LEN constants from the shared package wave_pkg.
REQ-025 SHALL place the compare/latch logic in one sub-module, trig_detect; address generation, prefetch and handshake stay in the top module.

Verification
REQ-026 SHALL cover a ramp RAM s[i]=i mod 256 with Gate=100 and Pix_Ready=1: expect T=100, Trig_Found=1, Pix_Data 100,101,...,255,0,..., 640 transfers, then one Done pulse.
REQ-027 SHALL cover a constant RAM of 50 with Gate=100: expect Trig_Found=0, a stream starting at address 0, 640 samples all equal to 50, and Done.
REQ-028 SHALL cover a single crossing at address 38399 (s[38398]=0, s[38399]=200, Gate=128): expect T=38399, streamed addresses 38399, 0, 1, ..., 638.
REQ-029 SHALL cover a ramp RAM with Pix_Ready driven by a random 30% duty: expect the sequence identical to REQ-026, Pix_Data stable during stalls, and exactly 640 transfers.
REQ-030 SHALL cover Rst pulsed low at the 300th transfer: expect all outputs 0 immediately and no Done; a following Start yields a complete, correct capture.
REQ-031 SHALL cover Start pulsed during STREAM: expect it ignored with transfer count still 640; with WAVE_TRIGGER_SLOPE_EN defined, Trig_Slope=1 on a descending ramp with Gate=100 gives T at the first s=100.
